dual_debouncer: RTL and testbench



---
 rtl/dual_debouncer_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 72 +++++++
 rtl/dual_debouncer.sv | 36 +++
 tb/tb_dual_debouncer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_debouncer_pkg.sv
// Shared constants and types for the two-channel PS/2 line debouncer.
package dual_debouncer_pkg;

    // PS/2 lines idle high; synchronizers and outputs reset to this level.
    localparam logic IDLE_LEVEL = 1'b1;

    // 20 cycles at 50 MHz = 400 ns of required stability.
    localparam int DEFAULT_STABLE_CYCLES = 20;

    // Legal range of the stability window. Below 2 the counter cannot count.
    localparam int MIN_STABLE_CYCLES = 2;
    localparam int MAX_STABLE_CYCLES = 1000;

    // What the filter does this cycle, given the synchronized level and output.
    typedef enum logic [1:0] {
        FILT_HOLD   = 2'd0,  // synchronized level equals output: clear count
        FILT_COUNT  = 2'd1,  // level differs, window not yet complete
        FILT_ACCEPT = 2'd2   // level differed for the full window: follow it
    } filt_action_e;

endpackage : dual_debouncer_pkg

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchronizer, stability counter and output flop.
// The output follows the synchronized input only after it has differed from
// the output for STABLE_CYCLES consecutive clocks; any cycle where it matches
// the output again restarts the count from zero.
module debounce_channel
    import dual_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES  // legal 2..1000
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic din,
    output logic dout
);

    // Wide enough to hold STABLE_CYCLES; derived, not meant to be overridden.
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    filt_action_e     w_action;

    // Decide this cycle's filter action from the synchronized level.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_action unassigned,
        // which would otherwise infer a latch.
        w_action = FILT_HOLD;
        if (r_sync2 != r_dout) begin
            if (r_cnt == CNT_LAST) begin
                w_action = FILT_ACCEPT;
            end else begin
                w_action = FILT_COUNT;
            end
        end
    end

    // Synchronizer, counter and output register; reset forces the idle level.
    always_ff @(posedge clk_50m) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values;
        // this is what keeps r_sync1 -> r_sync2 a true two-stage shift.
        if (rst) begin
            r_sync1 <= IDLE_LEVEL;
            r_sync2 <= IDLE_LEVEL;
            r_cnt   <= '0;
            r_dout  <= IDLE_LEVEL;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            case (w_action)
                FILT_HOLD: begin
                    r_cnt <= '0;
                end
                FILT_COUNT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FILT_ACCEPT: begin
                    r_dout <= r_sync2;
                    r_cnt  <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign dout = r_dout;

endmodule : debounce_channel

// File: rtl/dual_debouncer.sv
// Two independent debounce channels for the raw PS/2 lines:
// channel 0 filters kclk, channel 1 filters kdata. Both outputs are registered.
module dual_debouncer
    import dual_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES  // legal 2..1000
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic input0,
    input  logic input1,
    output logic output0,
    output logic output1
);

    // PS/2 clock line.
    debounce_channel #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch0 (
        .clk_50m (clk_50m),
        .rst     (rst),
        .din     (input0),
        .dout    (output0)
    );

    // PS/2 data line.
    debounce_channel #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch1 (
        .clk_50m (clk_50m),
        .rst     (rst),
        .din     (input1),
        .dout    (output1)
    );

endmodule : dual_debouncer

// File: tb/tb_dual_debouncer.sv
// Self-checking bench for dual_debouncer. Every accepted input transition
// pushes the expected output edge (edge number and level) onto a per-channel
// queue; a negedge monitor pops and compares whenever an output toggles.
module tb_dual_debouncer;

    localparam int STABLE = 20;
    localparam int LAT    = STABLE + 1;  // edges from t0 to the output switch
    localparam int HALF   = 2000;        // PS/2 half period in clk_50m cycles

    typedef struct {
        int   edge_no;
        logic val;
    } exp_t;

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;
    logic input0  = 1'b0;
    logic input1  = 1'b0;
    logic output0;
    logic output1;

    int   edge_cnt = 0;
    int   n_cmp    = 0;
    int   n_mis    = 0;
    exp_t q0[$];
    exp_t q1[$];

    bit   mon_en  = 1'b0;
    logic prev0   = 1'b1;
    logic prev1   = 1'b1;
    bit   ps2_cap = 1'b0;
    int   ps2_falls = 0;
    logic cap_bits[$];

    dual_debouncer #(
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .input0  (input0),
        .input1  (input1),
        .output0 (output0),
        .output1 (output1)
    );

    always #10 clk_50m = ~clk_50m;

    always @(posedge clk_50m) edge_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    task automatic on_change(input int ch, input logic val, input logic prev);
        exp_t e;
        int   qs;
        qs = (ch == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
            check($sformatf("unexpected_toggle_ch%0d", ch), {31'd0, val}, {31'd0, prev});
            return;
        end
        if (ch == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        check($sformatf("edge_ch%0d", ch), edge_cnt, e.edge_no);
        check($sformatf("level_ch%0d", ch), {31'd0, val}, {31'd0, e.val});
    endtask

    // Output monitor: compare every toggle against the scoreboard.
    always @(negedge clk_50m) begin
        if (mon_en) begin
            if (output0 !== prev0) begin
                on_change(0, output0, prev0);
                if (ps2_cap && prev0 === 1'b1 && output0 === 1'b0) begin
                    ps2_falls++;
                    cap_bits.push_back(output1);
                end
                prev0 = output0;
            end
            if (output1 !== prev1) begin
                on_change(1, output1, prev1);
                prev1 = output1;
            end
        end
    end

    task automatic set_in(input int ch, input logic val, output int t0);
        @(negedge clk_50m);
        if (ch == 0) input0 = val;
        else         input1 = val;
        t0 = edge_cnt + 1;
    endtask

    task automatic expect_at(input int ch, input logic val, input int t0);
        exp_t e;
        e.edge_no = t0 + LAT;
        e.val     = val;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // nseg (even) segments of 5 cycles alternating new/old level, then hold new.
    task automatic drive_bounced(input int ch, input logic val, input int nseg);
        int t0;
        for (int i = 0; i < nseg; i++) begin
            set_in(ch, (i % 2 == 0) ? val : ~val, t0);
            repeat (4) @(negedge clk_50m);
        end
        set_in(ch, val, t0);
        expect_at(ch, val, t0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clk_50m);
            n++;
        end
        check({tag, "_drain_ch0"}, q0.size(), 0);
        check({tag, "_drain_ch1"}, q1.size(), 0);
    endtask

    initial begin
        #(120_000 * 20);
        $display("FAIL watchdog: got timeout, want completion (edge %0d)", edge_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         t0;
        int         t1;
        logic [7:0] code;
        logic       frame[11];

        // Reset held 3 cycles with both raw inputs low.
        rst    = 1'b1;
        input0 = 1'b0;
        input1 = 1'b0;
        repeat (3) begin
            @(negedge clk_50m);
            check("reset_out0", {31'd0, output0}, 1);
            check("reset_out1", {31'd0, output1}, 1);
        end
        prev0  = 1'b1;
        prev1  = 1'b1;
        mon_en = 1'b1;
        rst    = 1'b0;
        t0     = edge_cnt + 1;
        expect_at(0, 1'b0, t0);
        expect_at(1, 1'b0, t0);
        @(negedge clk_50m);
        check("post_reset_out0", {31'd0, output0}, 1);
        check("post_reset_out1", {31'd0, output1}, 1);
        drain("reset_release", 60);

        // Simultaneous rise on both channels.
        @(negedge clk_50m);
        input0 = 1'b1;
        input1 = 1'b1;
        t0     = edge_cnt + 1;
        expect_at(0, 1'b1, t0);
        expect_at(1, 1'b1, t0);
        drain("simul_rise", 60);

        // Clean step on channel 0 only.
        set_in(0, 1'b0, t0);
        expect_at(0, 1'b0, t0);
        drain("step_fall", 60);
        set_in(0, 1'b1, t0);
        expect_at(0, 1'b1, t0);
        drain("step_rise", 60);

        // 19-cycle low pulse on channel 1 must be rejected.
        set_in(1, 1'b0, t0);
        repeat (18) @(negedge clk_50m);
        set_in(1, 1'b1, t1);
        check("glitch19_len", t1 - t0, 19);
        repeat (40) @(negedge clk_50m);
        check("glitch19_out1", {31'd0, output1}, 1);

        // 20-cycle low pulse on channel 1 passes as a 20-cycle output pulse.
        set_in(1, 1'b0, t0);
        repeat (19) @(negedge clk_50m);
        set_in(1, 1'b1, t1);
        expect_at(1, 1'b0, t0);
        expect_at(1, 1'b1, t1);
        drain("pulse20", 80);

        // Bounce every 5 cycles for 100 cycles, then settle low.
        drive_bounced(0, 1'b0, 20);
        drain("bounce_fall", 60);
        set_in(0, 1'b1, t0);
        expect_at(0, 1'b1, t0);
        drain("bounce_restore", 60);

        // Reset while channel 0 has counted to 10.
        set_in(0, 1'b0, t0);
        repeat (12) @(negedge clk_50m);
        check("midrst_setup", edge_cnt, t0 + 11);
        rst = 1'b1;
        @(negedge clk_50m);
        check("midrst_out0", {31'd0, output0}, 1);
        check("midrst_out1", {31'd0, output1}, 1);
        rst = 1'b0;
        t1  = edge_cnt + 1;
        expect_at(0, 1'b0, t1);
        drain("midrst_fall", 60);
        set_in(0, 1'b1, t0);
        expect_at(0, 1'b1, t0);
        drain("midrst_restore", 60);

        // PS/2 frame for scan code 0x1D with 2 us bounce on each edge.
        code     = 8'h1D;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[i + 1] = code[i];
        frame[9]  = ~(^code);
        frame[10] = 1'b1;
        ps2_cap   = 1'b1;
        for (int b = 0; b < 11; b++) begin
            if (input1 !== frame[b]) drive_bounced(1, frame[b], 20);
            repeat (HALF / 2) @(negedge clk_50m);
            drive_bounced(0, 1'b0, 20);
            repeat (HALF - 100) @(negedge clk_50m);
            drive_bounced(0, 1'b1, 20);
            repeat (HALF / 2 - 100) @(negedge clk_50m);
        end
        drain("ps2", 200);
        ps2_cap = 1'b0;
        check("ps2_falls", ps2_falls, 11);
        check("ps2_nbits", cap_bits.size(), 11);
        for (int b = 0; b < 11 && b < cap_bits.size(); b++) begin
            check($sformatf("ps2_bit%0d", b), {31'd0, cap_bits[b]}, {31'd0, frame[b]});
        end

        repeat (30) @(negedge clk_50m);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_dual_debouncer
